// File: rtl/alt_vipcti131_fifo_rd_pkg.sv
// Shared definitions for the clocked-video-input FIFO read controller:
// FSM state encoding, word field positions and the overflow counter width.
package alt_vipcti131_fifo_rd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FILL   = 3'd1,
      ST_STREAM = 3'd2,
      ST_FLUSH  = 3'd3,
      ST_RESYNC = 3'd4
   } rd_state_e;

   localparam int OVF_CNT_WIDTH = 8;

   // A FIFO word is {eop, sop, pixel}, so the flag positions follow the pixel width.
   function automatic int sop_bit(input int pixelWidth);
      return pixelWidth;
   endfunction

   function automatic int eop_bit(input int pixelWidth);
      return pixelWidth + 1;
   endfunction

endpackage

// File: rtl/alt_vipcti131_fifo_rd_skid.sv
// Two-entry buffer that absorbs the FIFO read latency; the incoming word is
// visible at the head in the same cycle it arrives when the buffer is empty.
module alt_vipcti131_fifo_rd_skid #(
   parameter int WIDTH = 20
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_clear,
   input  logic             i_limit1,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   input  logic             i_inflight,
   output logic             o_head_valid,
   output logic [WIDTH-1:0] o_head,
   output logic             o_empty,
   output logic             o_credit
);

   logic [WIDTH-1:0] r_mem0;
   logic [WIDTH-1:0] r_mem1;
   logic [1:0]       r_count;
   logic [WIDTH-1:0] w_e0;
   logic [WIDTH-1:0] w_e1;
   logic [1:0]       w_occ;
   logic [1:0]       w_cap;
   logic [1:0]       w_level;

   // Logical queue is {mem0, mem1, din} truncated to count+push entries.
   assign w_e0         = (r_count != 2'd0) ? r_mem0 : i_din;
   assign w_e1         = (r_count == 2'd2) ? r_mem1 : i_din;
   assign o_head       = w_e0;
   assign o_head_valid = (r_count != 2'd0) || i_push;
   assign o_empty      = (r_count == 2'd0);
   assign w_level      = r_count + {1'b0, i_push};

   assign w_occ    = r_count + {1'b0, i_inflight};
   assign w_cap    = i_limit1 ? 2'd1 : 2'd2;
   assign o_credit = (w_occ < w_cap) || ((w_occ == w_cap) && i_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= 2'd0;
         r_mem0  <= '0;
         r_mem1  <= '0;
      end else if (i_clear) begin
         r_count <= 2'd0;
      end else begin
         r_count <= w_level - {1'b0, i_pop};
         r_mem0  <= i_pop ? w_e1  : w_e0;
         r_mem1  <= i_pop ? i_din : w_e1;
      end
   end

endmodule

// File: rtl/alt_vipcti131_fifo_read_ctrl.sv
// Read-side controller for the CVI pixel FIFO: threshold start, Avalon-ST
// output, packet-boundary stop and overflow flush/resync to the next sop.
module alt_vipcti131_fifo_read_ctrl
   import alt_vipcti131_fifo_rd_pkg::*;
#(
   parameter  int PIXEL_WIDTH = 18,
   parameter  int FIFO_DEPTH  = 1920,
   parameter  int USEDW_WIDTH = $clog2(FIFO_DEPTH),
   parameter  int START_LEVEL = 8,
   localparam int DATA_WIDTH  = PIXEL_WIDTH + 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enable,
   output logic                     fifo_rdreq,
   input  logic [DATA_WIDTH-1:0]    fifo_q,
   input  logic                     fifo_rdempty,
   input  logic [USEDW_WIDTH-1:0]   fifo_rdusedw,
   input  logic                     overflow_in,
   output logic                     overflow_clear,
   output logic [PIXEL_WIDTH-1:0]   dout_data,
   output logic                     dout_sop,
   output logic                     dout_eop,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic                     packet_aborted,
   output logic [OVF_CNT_WIDTH-1:0] overflow_count,
   output logic [2:0]               state_out
);

   localparam int SOP_BIT = sop_bit(PIXEL_WIDTH);
   localparam int EOP_BIT = eop_bit(PIXEL_WIDTH);

   rd_state_e                r_state;
   rd_state_e                w_next_state;
   logic                     r_inflight;
   logic                     r_stopping;
   logic                     r_sop_open;
   logic                     r_packet_aborted;
   logic                     r_overflow_clear;
   logic [OVF_CNT_WIDTH-1:0] r_ovf_count;

   logic                     w_read_allowed;
   logic                     w_limit1;
   logic                     w_push;
   logic                     w_pop;
   logic                     w_ovf;
   logic                     w_stop_now;
   logic                     w_flush_done;
   logic                     w_credit;
   logic                     w_head_valid;
   logic                     w_empty;
   logic                     w_open_next;
   logic                     w_level_ok;
   logic [DATA_WIDTH-1:0]    w_head;

   // The sticky flag is not re-sampled while its clear pulse is in flight.
   assign w_ovf = overflow_in && !r_overflow_clear &&
                  ((r_state == ST_FILL) || (r_state == ST_STREAM) || (r_state == ST_RESYNC));
   assign w_stop_now   = (r_state == ST_STREAM) && r_inflight && fifo_q[EOP_BIT] && !enable;
   assign w_flush_done = (r_state == ST_FLUSH) && fifo_rdempty && !r_inflight;
   assign w_level_ok   = (fifo_rdusedw >= USEDW_WIDTH'(START_LEVEL));

   always_comb begin
      w_next_state   = r_state;
      w_read_allowed = 1'b0;
      w_limit1       = 1'b0;
      w_push         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (enable) w_next_state = ST_FILL;
         end
         ST_FILL: begin
            if (w_ovf)           w_next_state = ST_FLUSH;
            else if (!enable)    w_next_state = ST_IDLE;
            else if (w_level_ok) w_next_state = ST_STREAM;
         end
         ST_STREAM: begin
            w_read_allowed = !r_stopping && !w_stop_now;
            w_push         = r_inflight;
            if (w_ovf) w_next_state = ST_FLUSH;
            else if (r_stopping && w_empty && !r_inflight) w_next_state = ST_IDLE;
         end
         ST_FLUSH: begin
            w_read_allowed = 1'b1;
            if (w_flush_done) w_next_state = ST_RESYNC;
         end
         ST_RESYNC: begin
            w_read_allowed = 1'b1;
            w_limit1       = 1'b1;
            w_push         = r_inflight && fifo_q[SOP_BIT];
            if (w_ovf)       w_next_state = ST_FLUSH;
            else if (w_push) w_next_state = ST_FILL;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   alt_vipcti131_fifo_rd_skid #(.WIDTH(DATA_WIDTH)) u_skid (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_clear      (w_ovf),
      .i_limit1     (w_limit1),
      .i_push       (w_push),
      .i_din        (fifo_q),
      .i_pop        (w_pop),
      .i_inflight   (r_inflight),
      .o_head_valid (w_head_valid),
      .o_head       (w_head),
      .o_empty      (w_empty),
      .o_credit     (w_credit)
   );

   // Only STREAM presents data, so a sop word parked by RESYNC waits for the fill level.
   assign dout_valid = w_head_valid && (r_state == ST_STREAM);
   assign w_pop      = dout_valid && dout_ready;
   assign fifo_rdreq = w_read_allowed && !fifo_rdempty && w_credit;
   assign dout_data  = w_head[PIXEL_WIDTH-1:0];
   assign dout_sop   = w_head[SOP_BIT];
   assign dout_eop   = w_head[EOP_BIT];

   assign w_open_next = w_pop ? (w_head[EOP_BIT] ? 1'b0 : (w_head[SOP_BIT] | r_sop_open))
                              : r_sop_open;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state          <= ST_IDLE;
         r_inflight       <= 1'b0;
         r_stopping       <= 1'b0;
         r_sop_open       <= 1'b0;
         r_packet_aborted <= 1'b0;
         r_overflow_clear <= 1'b0;
         r_ovf_count      <= '0;
      end else begin
         r_state          <= w_next_state;
         r_inflight       <= fifo_rdreq;
         r_stopping       <= (w_next_state == ST_STREAM) && (r_stopping || w_stop_now);
         r_sop_open       <= w_ovf ? 1'b0 : w_open_next;
         r_packet_aborted <= w_ovf && w_open_next;
         r_overflow_clear <= w_flush_done;
         if (w_ovf && (r_ovf_count != '1)) r_ovf_count <= r_ovf_count + 1'b1;
      end
   end

   assign overflow_clear = r_overflow_clear;
   assign packet_aborted = r_packet_aborted;
   assign overflow_count = r_ovf_count;
   assign state_out      = r_state;

endmodule
